// File: rtl/lcd_time_writer.sv
// HD44780 8-bit writer: init sequence, then "HH:MM:SS" frames from a digit snapshot.
// Optional LCD_CHANGE_ONLY_EN: skip frames whose digits match the last one written.
module lcd_time_writer #(
   parameter int INIT_WAIT   = 750000,
   parameter int STROBE_CYC  = 25,
   parameter int CMD_WAIT    = 2500,
   parameter int CLR_WAIT    = 100000,
   parameter int REFRESH_CYC = 500000,
   parameter int COL         = 4
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [3:0] H10,
   input  logic [3:0] H1,
   input  logic [3:0] M10,
   input  logic [3:0] M1,
   input  logic [3:0] S10,
   input  logic [3:0] S1,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA,
   output logic       READY
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXV = imax(imax(INIT_WAIT, REFRESH_CYC),
                              STROBE_CYC + imax(CMD_WAIT, CLR_WAIT));
   localparam int CW = $clog2(MAXV + 1);

   localparam logic [CW-1:0] PWR_LAST  = CW'(INIT_WAIT - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(REFRESH_CYC - 1);
   localparam logic [CW-1:0] CMD_LAST  = CW'(STROBE_CYC + CMD_WAIT);
   localparam logic [CW-1:0] CLR_LAST  = CW'(STROBE_CYC + CLR_WAIT);
   localparam logic [CW-1:0] E_LAST    = CW'(STROBE_CYC);
   localparam logic [7:0]    ADDR_CMD  = 8'h80 | 8'(COL);

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT,
      ADDR,
      CHAR,
      IDLE
   } state_t;

   state_t        state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [2:0]    idx, nxt_idx;
   logic [23:0]   snap;
   logic [23:0]   live;
   logic          load_snap;
   logic          slot_end;
   logic          byte_state;
   logic          nxt_e;
   logic          nxt_rs;
   logic          nxt_ready;
   logic [7:0]    nxt_data;

   assign live   = {H10, H1, M10, M1, S10, S1};
   assign LCD_RW = 1'b0;

   function automatic logic [7:0] asc(input logic [3:0] d);
      return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h2D;
   endfunction

   function automatic logic [7:0] init_byte(input logic [2:0] i);
      logic [7:0] b;
      case (i)
         3'd0:    b = 8'h38;
         3'd1:    b = 8'h0C;
         3'd2:    b = 8'h06;
         default: b = 8'h01;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] char_byte(input logic [2:0]  i,
                                            input logic [23:0] s);
      logic [7:0] b;
      case (i)
         3'd0:    b = asc(s[23:20]);
         3'd1:    b = asc(s[19:16]);
         3'd3:    b = asc(s[15:12]);
         3'd4:    b = asc(s[11:8]);
         3'd6:    b = asc(s[7:4]);
         3'd7:    b = asc(s[3:0]);
         default: b = 8'h3A;
      endcase
      return b;
   endfunction

   // The clear command needs the long settle time instead of the normal one
   always_comb begin
      slot_end = (cnt == ((state == INIT && idx == 3'd3) ? CLR_LAST
                                                         : CMD_LAST));
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + CW'(1);
      nxt_idx   = idx;
      load_snap = 1'b0;
      unique case (state)
         PWR_WAIT: begin
            if (cnt == PWR_LAST) begin
               nxt_state = INIT;
               nxt_cnt   = '0;
               nxt_idx   = '0;
            end
         end
         INIT: begin
            if (slot_end) begin
               nxt_cnt = '0;
               if (idx == 3'd3) begin
                  nxt_state = ADDR;
                  nxt_idx   = '0;
                  load_snap = 1'b1;
               end else begin
                  nxt_idx = idx + 3'd1;
               end
            end
         end
         ADDR: begin
            if (slot_end) begin
               nxt_state = CHAR;
               nxt_cnt   = '0;
               nxt_idx   = '0;
            end
         end
         CHAR: begin
            if (slot_end) begin
               nxt_cnt = '0;
               if (idx == 3'd7) begin
                  nxt_state = IDLE;
                  nxt_idx   = '0;
               end else begin
                  nxt_idx = idx + 3'd1;
               end
            end
         end
         IDLE: begin
            if (cnt == IDLE_LAST) begin
               nxt_cnt = '0;
`ifdef LCD_CHANGE_ONLY_EN
               if (live != snap) begin
                  nxt_state = ADDR;
                  load_snap = 1'b1;
               end
`else
               nxt_state = ADDR;
               load_snap = 1'b1;
`endif
            end
         end
         default: begin
            nxt_state = PWR_WAIT;
            nxt_cnt   = '0;
            nxt_idx   = '0;
         end
      endcase
   end

   // Outputs are computed for the upcoming cycle and then registered
   always_comb begin
      byte_state = (nxt_state == INIT) || (nxt_state == ADDR) ||
                   (nxt_state == CHAR);
      nxt_e      = byte_state && (nxt_cnt != '0) && (nxt_cnt <= E_LAST);
      nxt_rs     = LCD_RS;
      nxt_data   = LCD_DATA;
      nxt_ready  = READY;
      if (byte_state && nxt_cnt == '0) begin
         unique case (1'b1)
            nxt_state == INIT: begin
               nxt_rs   = 1'b0;
               nxt_data = init_byte(nxt_idx);
            end
            nxt_state == ADDR: begin
               nxt_rs   = 1'b0;
               nxt_data = ADDR_CMD;
            end
            default: begin
               nxt_rs   = 1'b1;
               nxt_data = char_byte(nxt_idx, snap);
            end
         endcase
      end
      if (nxt_state == IDLE) begin
         nxt_ready = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state    <= PWR_WAIT;
         cnt      <= '0;
         idx      <= '0;
         snap     <= '0;
         LCD_E    <= 1'b0;
         LCD_RS   <= 1'b0;
         LCD_DATA <= 8'h00;
         READY    <= 1'b0;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         idx      <= nxt_idx;
         LCD_E    <= nxt_e;
         LCD_RS   <= nxt_rs;
         LCD_DATA <= nxt_data;
         READY    <= nxt_ready;
         if (load_snap) begin
            snap <= live;
         end
      end
   end

endmodule

// File: tb/tb_lcd_time_writer.sv
// Bench for lcd_time_writer: per-cycle bus trace compared with a frame-level model.
// Covers both builds of LCD_CHANGE_ONLY_EN.
module tb_lcd_time_writer;

   localparam int IW   = 10;
   localparam int S    = 2;
   localparam int CMD  = 5;
   localparam int CLR  = 20;
   localparam int R    = 50;
   localparam int COL  = 4;
   localparam int SLOT = 1 + S + CMD;
   localparam int INIT_LEN = IW + 3 * SLOT + 1 + S + CLR;
   localparam int FRAME = 9 * SLOT;

   logic       CLK = 1'b0;
   logic       RESETN = 1'b0;
   logic [3:0] H10, H1, M10, M1, S10, S1;
   logic       LCD_E, LCD_RS, LCD_RW, READY;
   logic [7:0] LCD_DATA;

   int errors = 0;
   int checks = 0;

   logic       exp_e[$];
   logic [8:0] exp_bus[$];
   bit         exp_chk[$];
   logic       act_e[$];
   logic [8:0] act_bus[$];
   logic       act_rdy[$];
   logic [23:0] cur_dig;

   always #5 CLK = ~CLK;

   lcd_time_writer #(
      .INIT_WAIT(IW), .STROBE_CYC(S), .CMD_WAIT(CMD),
      .CLR_WAIT(CLR), .REFRESH_CYC(R), .COL(COL)
   ) dut (
      .CLK(CLK), .RESETN(RESETN),
      .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1),
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .LCD_DATA(LCD_DATA), .READY(READY)
   );

   task automatic set_digits(input logic [23:0] v);
      {H10, H1, M10, M1, S10, S1} = v;
   endtask

   function automatic logic [23:0] rand_dig();
      logic [23:0] v;
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 3) == 0)
            v[4*k +: 4] = 4'($urandom_range(10, 15));
         else
            v[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   function automatic logic [7:0] ascii(input logic [3:0] d);
      string num;
      num = "0123456789";
      if (int'(d) < 10) return 8'(num[int'(d)]);
      return 8'h2D;
   endfunction

   function automatic void m_clear();
      exp_e.delete(); exp_bus.delete(); exp_chk.delete();
      act_e.delete(); act_bus.delete(); act_rdy.delete();
   endfunction

   function automatic void m_idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_e.push_back(1'b0);
         exp_bus.push_back(9'h0);
         exp_chk.push_back(1'b0);
      end
   endfunction

   function automatic void m_byte(input bit rs, input logic [7:0] b,
                                  input int w);
      for (int i = 0; i < 1 + S + w; i++) begin
         exp_e.push_back(logic'(i >= 1 && i <= S));
         exp_bus.push_back({rs, b});
         exp_chk.push_back(1'b1);
      end
   endfunction

   function automatic void m_init();
      m_idle(IW);
      m_byte(1'b0, 8'h38, CMD);
      m_byte(1'b0, 8'h0C, CMD);
      m_byte(1'b0, 8'h06, CMD);
      m_byte(1'b0, 8'h01, CLR);
   endfunction

   function automatic void m_frame(input logic [23:0] v);
      logic [7:0] t[8];
      t[0] = ascii(v[23:20]); t[1] = ascii(v[19:16]); t[2] = 8'h3A;
      t[3] = ascii(v[15:12]); t[4] = ascii(v[11:8]);  t[5] = 8'h3A;
      t[6] = ascii(v[7:4]);   t[7] = ascii(v[3:0]);
      m_byte(1'b0, 8'h80 + 8'(COL), CMD);
      for (int i = 0; i < 8; i++) m_byte(1'b1, t[i], CMD);
   endfunction

   task automatic cap(input int n);
      for (int i = 0; i < n; i++) begin
         act_e.push_back(LCD_E);
         act_bus.push_back({LCD_RS, LCD_DATA});
         act_rdy.push_back(READY);
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      RESETN = 1'b0;
      set_digits(24'h123456);
      repeat (3) @(negedge CLK);
      checks++;
      if (LCD_E !== 1'b0) begin
         errors++; $display("FAIL reset_e: got %b need 0", LCD_E);
      end
      checks++;
      if (LCD_RS !== 1'b0) begin
         errors++; $display("FAIL reset_rs: got %b need 0", LCD_RS);
      end
      checks++;
      if (LCD_RW !== 1'b0) begin
         errors++; $display("FAIL reset_rw: got %b need 0", LCD_RW);
      end
      checks++;
      if (LCD_DATA !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %h need 00", LCD_DATA);
      end
      checks++;
      if (READY !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b need 0", READY);
      end
   endtask

   task automatic test_init();
      int bad;
      m_clear();
      RESETN = 1'b1;
      m_init();
      cap(INIT_LEN);
      for (int i = 0; i < exp_e.size(); i++) begin
         checks++;
         if (act_e[i] !== exp_e[i] ||
             (exp_chk[i] && act_bus[i] !== exp_bus[i])) begin
            errors++;
            if (errors < 30)
               $display("FAIL init cyc %0d: E=%b RS/DATA=%h need E=%b RS/DATA=%h",
                        i, act_e[i], act_bus[i], exp_e[i], exp_bus[i]);
         end
      end
      bad = 0;
      foreach (act_rdy[i]) if (act_rdy[i] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL init_ready: %0d cycles high, need 0", bad);
      end
   endtask

   task automatic test_first_frame(input logic [23:0] nxt);
      int bad;
      m_clear();
      m_frame(24'h123456);
      m_idle(R);
      cap(FRAME + R - 10);
      set_digits(nxt);
      cap(10);
      for (int i = 0; i < exp_e.size(); i++) begin
         checks++;
         if (act_e[i] !== exp_e[i] ||
             (exp_chk[i] && act_bus[i] !== exp_bus[i])) begin
            errors++;
            if (errors < 30)
               $display("FAIL frame1 cyc %0d: E=%b RS/DATA=%h need E=%b RS/DATA=%h",
                        i, act_e[i], act_bus[i], exp_e[i], exp_bus[i]);
         end
      end
      bad = 0;
      foreach (act_rdy[i]) if (act_rdy[i] !== logic'(i >= FRAME)) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL frame1_ready: %0d cycles wrong, need 0", bad);
      end
      cur_dig = nxt;
   endtask

   task automatic test_snapshot();
      logic [23:0] b;
      b = 24'h123500;
      m_clear();
      m_frame(cur_dig);
      m_idle(R);
      m_frame(b);
      m_idle(R);
      cap(5 * SLOT + 3);
      set_digits(b);
      cap(4 * SLOT - 3 + R + FRAME + R - 10);
      set_digits(24'hC00000);
      cap(10);
      for (int i = 0; i < exp_e.size(); i++) begin
         checks++;
         if (act_e[i] !== exp_e[i] ||
             (exp_chk[i] && act_bus[i] !== exp_bus[i])) begin
            errors++;
            if (errors < 30)
               $display("FAIL snapshot cyc %0d: E=%b RS/DATA=%h need E=%b RS/DATA=%h",
                        i, act_e[i], act_bus[i], exp_e[i], exp_bus[i]);
         end
      end
      cur_dig = 24'hC00000;
   endtask

   task automatic test_dash();
      logic [23:0] nxt;
      m_clear();
      m_frame(cur_dig);
      m_idle(R);
      cap(FRAME + R - 10);
      nxt = rand_dig();
      set_digits(nxt);
      cap(10);
      for (int i = 0; i < exp_e.size(); i++) begin
         checks++;
         if (act_e[i] !== exp_e[i] ||
             (exp_chk[i] && act_bus[i] !== exp_bus[i])) begin
            errors++;
            if (errors < 30)
               $display("FAIL dash cyc %0d: E=%b RS/DATA=%h need E=%b RS/DATA=%h",
                        i, act_e[i], act_bus[i], exp_e[i], exp_bus[i]);
         end
      end
      checks++;
      if (act_bus[SLOT] !== {1'b1, 8'h2D}) begin
         errors++;
         $display("FAIL dash_first_char: got %h need 12d", act_bus[SLOT]);
      end
      cur_dig = nxt;
   endtask

   task automatic test_random_frames();
      logic [23:0] nxt;
      m_clear();
      for (int f = 0; f < 4; f++) begin
         m_frame(cur_dig);
         m_idle(R);
         cap(FRAME + R - 10);
         nxt = rand_dig();
         set_digits(nxt);
         cap(10);
         cur_dig = nxt;
      end
      for (int i = 0; i < exp_e.size(); i++) begin
         checks++;
         if (act_e[i] !== exp_e[i] ||
             (exp_chk[i] && act_bus[i] !== exp_bus[i])) begin
            errors++;
            if (errors < 30)
               $display("FAIL random cyc %0d: E=%b RS/DATA=%h need E=%b RS/DATA=%h",
                        i, act_e[i], act_bus[i], exp_e[i], exp_bus[i]);
         end
      end
   endtask

`ifdef LCD_CHANGE_ONLY_EN
   task automatic test_change_only();
      int rises;
      int bad;
      m_clear();
      m_idle(3 * R);
      m_idle(R);
      m_frame(24'h123457);
      m_idle(3 * R);
      cap(3 * R + 10);
      set_digits(24'h123457);
      cap(R - 10 + FRAME + 3 * R);
      for (int i = 0; i < exp_e.size(); i++) begin
         checks++;
         if (act_e[i] !== exp_e[i] ||
             (exp_chk[i] && act_bus[i] !== exp_bus[i])) begin
            errors++;
            if (errors < 30)
               $display("FAIL change_only cyc %0d: E=%b RS/DATA=%h need E=%b RS/DATA=%h",
                        i, act_e[i], act_bus[i], exp_e[i], exp_bus[i]);
         end
      end
      rises = 0;
      for (int i = 1; i < act_e.size(); i++)
         if (act_e[i] === 1'b1 && act_e[i-1] === 1'b0) rises++;
      checks++;
      if (rises != 9) begin
         errors++; $display("FAIL change_only_pulses: got %0d need 9", rises);
      end
      bad = 0;
      foreach (act_rdy[i]) if (act_rdy[i] !== 1'b1) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL change_only_ready: %0d cycles low, need 0", bad);
      end
   endtask
`endif

   task automatic test_reset_mid_byte();
      logic [23:0] p, q;
      int bad;
      p = rand_dig();
      q = p ^ 24'h000001;
      RESETN = 1'b0;
      set_digits(p);
      @(negedge CLK);
      RESETN = 1'b1;
      repeat (INIT_LEN + FRAME + R - 10) @(negedge CLK);
      set_digits(q);
      repeat (10 + 2 * SLOT + 1) @(negedge CLK);
      checks++;
      if ({LCD_E, LCD_RS, LCD_DATA, READY} !== {2'b11, ascii(q[19:16]), 1'b1}) begin
         errors++;
         $display("FAIL midbyte_pre: E=%b RS=%b DATA=%h RDY=%b need 1 1 %h 1",
                  LCD_E, LCD_RS, LCD_DATA, READY, ascii(q[19:16]));
      end
      #2 RESETN = 1'b0;
      #1;
      checks++;
      if ({LCD_E, LCD_RS, LCD_RW, LCD_DATA, READY} !== 12'h000) begin
         errors++;
         $display("FAIL midbyte_reset: E=%b RS=%b RW=%b DATA=%h RDY=%b need all 0",
                  LCD_E, LCD_RS, LCD_RW, LCD_DATA, READY);
      end
      @(negedge CLK);
      @(negedge CLK);
      m_clear();
      RESETN = 1'b1;
      m_init();
      m_frame(q);
      cap(INIT_LEN + FRAME);
      for (int i = 0; i < exp_e.size(); i++) begin
         checks++;
         if (act_e[i] !== exp_e[i] ||
             (exp_chk[i] && act_bus[i] !== exp_bus[i])) begin
            errors++;
            if (errors < 30)
               $display("FAIL restart cyc %0d: E=%b RS/DATA=%h need E=%b RS/DATA=%h",
                        i, act_e[i], act_bus[i], exp_e[i], exp_bus[i]);
         end
      end
      bad = 0;
      foreach (act_rdy[i]) if (act_rdy[i] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL restart_ready: %0d cycles high, need 0", bad);
      end
   endtask

   initial begin
      set_digits(24'h0);
      cur_dig = 24'h0;
      test_reset();
      test_init();
`ifdef LCD_CHANGE_ONLY_EN
      test_first_frame(24'h123456);
      test_change_only();
`else
      test_first_frame(24'h123459);
      test_snapshot();
      test_dash();
      test_random_frames();
`endif
      test_reset_mid_byte();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
